sprite_cmd_sched: RTL and testbench

Command scheduler that sits directly upstream of the sprite display components (e.g. the mushroom display). It accepts 32-bit command words from the CPU over an Avalon-MM write slave and buffers them in a FIFO. It replays them onto the shared `writedata` bus at one word per cycle, and forces each update into the current back buffer. Buffer flips (flush commands) are held until vertical blanking, so sprite state only swaps between frames.

---
 rtl/sprite_cmd_sched.sv | 144 ++++++++++++++
 tb/tb_sprite_cmd_sched.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/sprite_cmd_sched.sv
// Sprite command scheduler: buffers CPU command words, replays them onto the display
// bus into the back buffer, and holds buffer flips until vertical blanking.
module sprite_cmd_sched #(
   parameter int unsigned DEPTH      = 16,
   parameter int unsigned FLUSH_LINE = 480
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       avs_write,
   input  logic [31:0]                avs_writedata,
   output logic                       avs_waitrequest,
   input  logic [9:0]                 hcount,
   input  logic [9:0]                 vcount,
   output logic [31:0]                writedata,
   output logic                       buf_sel,
   output logic                       frame_pending,
   output logic [$clog2(DEPTH):0]     fifo_level
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned LW = AW + 1;
   localparam logic [3:0] CTRL_UPDATE = 4'h1;
   localparam logic [3:0] CTRL_FLUSH  = 4'hF;

   typedef enum logic [1:0] {
      S_IDLE,
      S_ISSUE,
      S_WAIT_VB,
      S_FLUSH
   } state_e;

   state_e          state_q, state_d;
   logic [31:0]     mem [DEPTH];
   logic [AW-1:0]   wr_ptr_q, rd_ptr_q;
   logic [LW-1:0]   level_q, level_d;
   logic [LW-1:0]   mark_cnt_q, mark_cnt_d;
   logic [31:0]     wdata_q, wdata_d;
   logic            buf_sel_q, buf_sel_d;
   logic            flipped_q, flipped_d;

   logic [3:0]      wr_ctrl;
   logic            accept, push, push_mark;
   logic [31:0]     head;
   logic            head_is_mark, not_empty, in_vb;
   logic            pop, pop_mark;
   logic            unused_c;

   assign unused_c = ^hcount;

   assign wr_ctrl      = avs_writedata[20:17];
   assign accept       = avs_write && !avs_waitrequest;
   assign push         = accept && ((wr_ctrl == CTRL_UPDATE) || (wr_ctrl == CTRL_FLUSH));
   assign push_mark    = accept && (wr_ctrl == CTRL_FLUSH);
   assign head         = mem[rd_ptr_q];
   assign head_is_mark = (head[20:17] == CTRL_FLUSH);
   assign not_empty    = (level_q != '0);
   assign in_vb        = (32'(vcount) >= FLUSH_LINE);

   // Next-state, pop decision and bus word; a pop is always paired with a driven word.
   always_comb begin
      state_d   = state_q;
      wdata_d   = '0;
      pop       = 1'b0;
      pop_mark  = 1'b0;
      buf_sel_d = buf_sel_q;
      flipped_d = in_vb ? flipped_q : 1'b0;
      case (state_q)
         S_WAIT_VB: begin
            if (in_vb && !flipped_q) begin
               pop      = 1'b1;
               pop_mark = 1'b1;
               wdata_d  = {head[31:14], ~buf_sel_q, head[12:0]};
               state_d  = S_FLUSH;
            end
         end
         default: begin
            // Leaving FLUSH: the flip lands now, so the next update targets the new back buffer.
            if (state_q == S_FLUSH) begin
               buf_sel_d = ~buf_sel_q;
               flipped_d = 1'b1;
            end
            state_d = S_IDLE;
            if (not_empty) begin
               if (head_is_mark) begin
                  state_d = S_WAIT_VB;
               end else begin
                  pop     = 1'b1;
                  wdata_d = {head[31:14], ~buf_sel_d, head[12:0]};
                  state_d = S_ISSUE;
               end
            end
         end
      endcase
   end

   always_comb begin
      level_d = level_q;
      case ({push, pop})
         2'b10:   level_d = level_q + LW'(1);
         2'b01:   level_d = level_q - LW'(1);
         default: level_d = level_q;
      endcase
      mark_cnt_d = mark_cnt_q;
      case ({push_mark, pop_mark})
         2'b10:   mark_cnt_d = mark_cnt_q + LW'(1);
         2'b01:   mark_cnt_d = mark_cnt_q - LW'(1);
         default: mark_cnt_d = mark_cnt_q;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q    <= S_IDLE;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         level_q    <= '0;
         mark_cnt_q <= '0;
         wdata_q    <= '0;
         buf_sel_q  <= 1'b0;
         flipped_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         level_q    <= level_d;
         mark_cnt_q <= mark_cnt_d;
         wdata_q    <= wdata_d;
         buf_sel_q  <= buf_sel_d;
         flipped_q  <= flipped_d;
         if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
         if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      end
   end

   // Storage needs no reset; the level register defines which entries are valid.
   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr_q] <= avs_writedata;
   end

   assign avs_waitrequest = (level_q == LW'(DEPTH));
   assign frame_pending   = (mark_cnt_q != '0);
   assign writedata       = wdata_q;
   assign buf_sel         = buf_sel_q;
   assign fifo_level      = level_q;

endmodule

// File: tb/tb_sprite_cmd_sched.sv
// Directed bench for sprite_cmd_sched: update, discard, flip, ordering, double marker,
// backpressure and reset while full.
module tb_sprite_cmd_sched;

   logic        clk = 1'b0;
   logic        reset;
   logic        avs_write;
   logic [31:0] avs_writedata;
   logic        avs_waitrequest;
   logic [9:0]  hcount;
   logic [9:0]  vcount;
   logic [31:0] writedata;
   logic        buf_sel;
   logic        frame_pending;
   logic [4:0]  fifo_level;

   int tests = 0;
   int fails = 0;

   sprite_cmd_sched #(.DEPTH(16), .FLUSH_LINE(480)) dut (
      .clk             (clk),
      .reset           (reset),
      .avs_write       (avs_write),
      .avs_writedata   (avs_writedata),
      .avs_waitrequest (avs_waitrequest),
      .hcount          (hcount),
      .vcount          (vcount),
      .writedata       (writedata),
      .buf_sel         (buf_sel),
      .frame_pending   (frame_pending),
      .fifo_level      (fifo_level)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   task automatic wr(input logic [31:0] d);
      avs_write     = 1'b1;
      avs_writedata = d;
      tick();
      avs_write     = 1'b0;
   endtask

   initial begin
      reset = 1'b0; avs_write = 1'b0; avs_writedata = '0; hcount = '0; vcount = 10'd100;
      repeat (3) tick();
      reset = 1'b1;
      tick();
      chk("rst_wdata",   writedata, 32'h0);
      chk("rst_bufsel",  32'(buf_sel), 32'h0);
      chk("rst_waitreq", 32'(avs_waitrequest), 32'h0);
      chk("rst_level",   32'(fifo_level), 32'h0);
      chk("rst_pending", 32'(frame_pending), 32'h0);

      // Single update, bit 13 forced to ~buf_sel = 1
      wr(32'h24225800);
      chk("upd_lat0",  writedata, 32'h0);
      chk("upd_lvl1",  32'(fifo_level), 32'h1);
      tick();
      chk("upd_word",  writedata, 32'h24227800);
      chk("upd_lvl0",  32'(fifo_level), 32'h0);
      tick();
      chk("upd_after", writedata, 32'h0);

      // Unknown control code is discarded
      wr(32'h00040000);
      chk("disc_lvl", 32'(fifo_level), 32'h0);
      tick();
      chk("disc_wd",  writedata, 32'h0);

      // Flip held until vblank
      wr(32'h001E0000);
      chk("flip_lvl",  32'(fifo_level), 32'h1);
      chk("flip_pend", 32'(frame_pending), 32'h1);
      repeat (4) begin
         tick();
         chk("flip_hold", writedata, 32'h0);
      end
      chk("flip_pend2", 32'(frame_pending), 32'h1);
      vcount = 10'd480;
      tick();
      chk("flip_word",   writedata, 32'h001E2000);
      chk("flip_bs_old", 32'(buf_sel), 32'h0);
      tick();
      chk("flip_after",  writedata, 32'h0);
      chk("flip_bs_new", 32'(buf_sel), 32'h1);
      chk("flip_pend0",  32'(frame_pending), 32'h0);
      vcount = 10'd100;
      tick();

      // Reset pulse returns buf_sel to 0
      reset = 1'b0;
      #1;
      chk("rst2_bufsel", 32'(buf_sel), 32'h0);
      tick();
      reset = 1'b1;
      tick();

      // Ordering: update behind marker waits, then carries the new back buffer (0)
      wr(32'h001E0000);
      wr(32'h24225800);
      chk("ord_lvl2", 32'(fifo_level), 32'h2);
      tick(); tick();
      chk("ord_hold", writedata, 32'h0);
      chk("ord_lvl",  32'(fifo_level), 32'h2);
      vcount = 10'd480;
      tick();
      chk("ord_flush", writedata, 32'h001E2000);
      tick();
      chk("ord_upd",   writedata, 32'h24225800);
      chk("ord_bs",    32'(buf_sel), 32'h1);
      tick();
      chk("ord_after", writedata, 32'h0);
      chk("ord_lvl0",  32'(fifo_level), 32'h0);

      // Double marker: one flip per blanking interval
      vcount = 10'd100;
      tick();
      wr(32'h001E0000);
      wr(32'h001E0000);
      chk("dbl_lvl2", 32'(fifo_level), 32'h2);
      tick();
      vcount = 10'd480;
      tick();
      chk("dbl_flush1", writedata, 32'h001E0000);
      tick();
      chk("dbl_bs0",   32'(buf_sel), 32'h0);
      chk("dbl_lvl1",  32'(fifo_level), 32'h1);
      chk("dbl_pend",  32'(frame_pending), 32'h1);
      repeat (5) begin
         tick();
         chk("dbl_hold", writedata, 32'h0);
      end
      chk("dbl_bs_hold", 32'(buf_sel), 32'h0);
      vcount = 10'd100;
      tick(); tick();
      chk("dbl_hold2", writedata, 32'h0);
      vcount = 10'd480;
      tick();
      chk("dbl_flush2", writedata, 32'h001E2000);
      tick();
      chk("dbl_bs1",   32'(buf_sel), 32'h1);
      chk("dbl_pend0", 32'(frame_pending), 32'h0);
      chk("dbl_after", writedata, 32'h0);

      // Backpressure: marker plus 15 updates fill the FIFO
      vcount = 10'd100;
      tick();
      wr(32'h001E0000);
      for (int i = 0; i < 15; i++) wr(32'h24225800 | 32'(i));
      chk("bp_lvl",     32'(fifo_level), 32'd16);
      chk("bp_waitreq", 32'(avs_waitrequest), 32'h1);
      chk("bp_pend",    32'(frame_pending), 32'h1);
      avs_write     = 1'b1;
      avs_writedata = 32'h24220001;
      repeat (3) begin
         tick();
         chk("bp_held", 32'(fifo_level), 32'd16);
         chk("bp_wd",   writedata, 32'h0);
      end

      // Reset while full, entering vblank: nothing queued survives, no flush
      vcount = 10'd480;
      reset  = 1'b0;
      #1;
      avs_write = 1'b0;
      chk("rst3_lvl",     32'(fifo_level), 32'h0);
      chk("rst3_bufsel",  32'(buf_sel), 32'h0);
      chk("rst3_waitreq", 32'(avs_waitrequest), 32'h0);
      chk("rst3_pend",    32'(frame_pending), 32'h0);
      tick();
      reset = 1'b1;
      repeat (3) begin
         tick();
         chk("rst3_noflush", writedata, 32'h0);
         chk("rst3_lvl0",    32'(fifo_level), 32'h0);
      end
      chk("rst3_bs_end", 32'(buf_sel), 32'h0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
